// File: rtl/i2c_target_rx_pkg.sv
// i2c_target_rx_pkg: shared FSM encoding and address-match helper for the I2C target receiver
package i2c_target_rx_pkg;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_DATA,
    ST_DATA_ACK,
    ST_IGNORE
  } state_t;
  localparam logic I2C_WRITE = 1'b0;
  function automatic logic addr_match(input logic [7:0] b, input logic [6:0] a);
    return (b[7:1] == a) && (b[0] == I2C_WRITE);
  endfunction
endpackage

// File: rtl/i2c_target_rx_line_filter.sv
// i2c_target_rx_line_filter: 2-flop sync, stability filter and edge pulses for one bus line
module i2c_target_rx_line_filter #(
  parameter int FILT_LEN = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic line_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);
  localparam int CW = $clog2(FILT_LEN + 1);
  localparam logic [CW-1:0] LAST = CW'(FILT_LEN - 1);
  logic sync1_q, sync2_q, filt_q, rise_q, fall_q, accept;
  logic [CW-1:0] cnt_q, cnt_d;
  assign accept = (sync2_q != filt_q) && (cnt_q == LAST);
  assign cnt_d = (sync2_q == filt_q || accept) ? '0 : cnt_q + CW'(1);
  // sync, count how long the synced level differs, accept it after FILT_LEN cycles
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      filt_q  <= 1'b1;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= line_i;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      filt_q  <= accept ? sync2_q : filt_q;
      rise_q  <= accept & sync2_q;
      fall_q  <= accept & ~sync2_q;
    end
  end
  assign level_o = filt_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;
endmodule

// File: rtl/i2c_target_rx.sv
// i2c_target_rx: I2C write-only target; detects START/STOP, matches address, ACKs and delivers bytes
module i2c_target_rx
  import i2c_target_rx_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = 7'h72,
  parameter int         FILT_LEN   = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe_o,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  output logic       addr_hit_o,
  output logic       busy_o
);
  logic scl_lvl, scl_rise, scl_fall, sda_lvl, sda_rise, sda_fall;
  logic start, stop, bit_rise;
  state_t state_q, state_d;
  logic [7:0] shreg_q, shreg_d, rx_data_q, rx_data_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic full_q, full_d, sda_oe_q, sda_oe_d, rx_valid_q, rx_valid_d;
  logic addr_hit_q, addr_hit_d, busy_q, busy_d;

  i2c_target_rx_line_filter #(.FILT_LEN(FILT_LEN)) u_scl (
    .clk(clk), .rst(rst), .line_i(scl_i), .level_o(scl_lvl), .rise_o(scl_rise), .fall_o(scl_fall)
  );
  i2c_target_rx_line_filter #(.FILT_LEN(FILT_LEN)) u_sda (
    .clk(clk), .rst(rst), .line_i(sda_i), .level_o(sda_lvl), .rise_o(sda_rise), .fall_o(sda_fall)
  );

  assign start    = sda_fall & scl_lvl;
  assign stop     = sda_rise & scl_lvl;
  assign bit_rise = scl_rise & ~start & ~stop & (state_q == ST_ADDR || state_q == ST_DATA);

  // state register
  always_ff @(posedge clk) begin
    state_q <= !rst ? ST_IDLE : state_d;
  end

  // next state: START/STOP win over SCL edges, byte/ACK boundaries act on SCL fall
  always_comb begin
    state_d = state_q;
    if (start) state_d = ST_ADDR;
    else if (stop) state_d = ST_IDLE;
    else if (scl_fall)
      case (state_q)
        ST_ADDR:                  if (full_q) state_d = addr_match(shreg_q, SLAVE_ADDR) ? ST_ADDR_ACK : ST_IGNORE;
        ST_ADDR_ACK, ST_DATA_ACK: state_d = ST_DATA;
        ST_DATA:                  if (full_q) state_d = ST_DATA_ACK;
        default:                  state_d = state_q;
      endcase
  end

  // datapath and output next values; ACK drive and flags follow the next state directly
  always_comb begin
    shreg_d    = bit_rise ? {shreg_q[6:0], sda_lvl} : shreg_q;
    bit_cnt_d  = (start | stop) ? 3'd0 : bit_rise ? bit_cnt_q + 3'd1 : bit_cnt_q;
    full_d     = (start | stop | scl_fall) ? 1'b0 : bit_rise ? (bit_cnt_q == 3'd7) : full_q;
    sda_oe_d   = (state_d == ST_ADDR_ACK) || (state_d == ST_DATA_ACK);
    addr_hit_d = (state_d == ST_DATA) || (state_d == ST_DATA_ACK);
    busy_d     = state_d != ST_IDLE;
    rx_valid_d = (state_q == ST_DATA) && (state_d == ST_DATA_ACK);
    rx_data_d  = rx_valid_d ? shreg_q : rx_data_q;
  end

  // datapath and output registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      shreg_q    <= '0;
      bit_cnt_q  <= '0;
      full_q     <= 1'b0;
      sda_oe_q   <= 1'b0;
      addr_hit_q <= 1'b0;
      busy_q     <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
    end else begin
      shreg_q    <= shreg_d;
      bit_cnt_q  <= bit_cnt_d;
      full_q     <= full_d;
      sda_oe_q   <= sda_oe_d;
      addr_hit_q <= addr_hit_d;
      busy_q     <= busy_d;
      rx_valid_q <= rx_valid_d;
      rx_data_q  <= rx_data_d;
    end
  end

  assign sda_oe_o   = sda_oe_q;
  assign addr_hit_o = addr_hit_q;
  assign busy_o     = busy_q;
  assign rx_valid_o = rx_valid_q;
  assign rx_data_o  = rx_data_q;
endmodule

// File: tb/tb_i2c_target_rx.sv
// tb_i2c_target_rx: bit-banged I2C master with transaction-level expectations for i2c_target_rx
module tb_i2c_target_rx;
  localparam int Q = 20;
  localparam logic [6:0] ADDR = 7'h72;
  logic clk = 1'b0, rst = 1'b0, m_scl = 1'b1, m_sda = 1'b1, glitch = 1'b0;
  logic sda_bus, sda_oe_o, rx_valid_o, addr_hit_o, busy_o;
  logic [7:0] rx_data_o;
  logic settled = 1'b0, exp_busy = 1'b0, exp_hit = 1'b0, exp_oe = 1'b0;
  int checks = 0, errors = 0, nvalid = 0, oe_cnt = 0;
  logic [7:0] exp_q[$];
  logic [7:0] seen[$];
  event glitch_ev;

  always #5 clk = ~clk;
  assign sda_bus = m_sda & ~glitch & ~sda_oe_o;

  i2c_target_rx #(.SLAVE_ADDR(ADDR), .FILT_LEN(3)) dut (
    .clk(clk), .rst(rst), .scl_i(m_scl), .sda_i(sda_bus), .sda_oe_o(sda_oe_o),
    .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o), .addr_hit_o(addr_hit_o), .busy_o(busy_o)
  );

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endfunction

  // compare process: delivered bytes always, bus-facing flags once the line state has settled
  always @(negedge clk) begin
    if (rst) begin
      if (rx_valid_o) begin
        nvalid++;
        seen.push_back(rx_data_o);
        if (exp_q.size() == 0) chk("rx_valid_extra", 32'(rx_valid_o), 32'd0);
        else chk("rx_data", 32'(rx_data_o), 32'(exp_q.pop_front()));
      end
      if (sda_oe_o) oe_cnt++;
      if (settled) begin
        chk("busy", 32'(busy_o), 32'(exp_busy));
        chk("addr_hit", 32'(addr_hit_o), 32'(exp_hit));
        chk("sda_oe", 32'(sda_oe_o), 32'(exp_oe));
      end
    end
  end

  // two-cycle low glitch on SDA, placed a few cycles after the request
  always begin
    @(glitch_ev);
    repeat (6) @(negedge clk);
    glitch = 1'b1;
    repeat (2) @(negedge clk);
    glitch = 1'b0;
  end

  task automatic step(input logic c, input logic d);
    m_scl = c;
    m_sda = d;
    settled = 1'b0;
    repeat (Q / 2) @(negedge clk);
    settled = 1'b1;
    repeat (Q / 2) @(negedge clk);
    settled = 1'b0;
    #1;
  endtask

  task automatic do_start;
    if (!m_scl) begin
      step(1'b0, 1'b1);
      step(1'b1, 1'b1);
    end
    exp_busy = 1'b1;
    exp_hit = 1'b0;
    exp_oe = 1'b0;
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
  endtask

  task automatic do_stop;
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    exp_busy = 1'b0;
    exp_hit = 1'b0;
    exp_oe = 1'b0;
    step(1'b1, 1'b1);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit is_addr, input int gi, output logic ack);
    ack = is_addr ? (b[7:1] == ADDR && !b[0]) : exp_hit;
    for (int i = 7; i >= 0; i--) begin
      step(1'b0, b[i]);
      if (i == gi) -> glitch_ev;
      step(1'b1, b[i]);
      if (i == 0 && ack) begin
        exp_oe = 1'b1;
        if (!is_addr) exp_q.push_back(b);
      end
      step(1'b0, b[i]);
    end
  endtask

  task automatic ack_bit(input logic ack, input bit is_addr);
    step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    chk("ack_level", 32'(sda_bus), 32'(ack ? 1'b0 : 1'b1));
    exp_oe = 1'b0;
    if (is_addr) exp_hit = ack;
    step(1'b0, 1'b1);
  endtask

  task automatic partial(input logic [7:0] b, input int n);
    for (int i = 7; i >= 8 - n; i--) begin
      step(1'b0, b[i]);
      step(1'b1, b[i]);
      step(1'b0, b[i]);
    end
  endtask

  task automatic addr_phase(input logic [7:0] a);
    logic k;
    send_byte(a, 1'b1, -1, k);
    ack_bit(k, 1'b1);
  endtask

  task automatic data_byte(input logic [7:0] d, input int gi);
    logic k;
    send_byte(d, 1'b0, gi, k);
    ack_bit(k, 1'b0);
  endtask

  initial begin
    int v0, o0, s0, nb;
    logic k;
    logic [6:0] a;
    repeat (5) @(negedge clk);
    chk("rst_sda_oe", 32'(sda_oe_o), 32'd0);
    chk("rst_rx_valid", 32'(rx_valid_o), 32'd0);
    chk("rst_rx_data", 32'(rx_data_o), 32'd0);
    chk("rst_addr_hit", 32'(addr_hit_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    rst = 1'b1;
    #1;
    v0 = nvalid;
    do_start;
    addr_phase(8'hE4);
    data_byte(8'hA5, -1);
    do_stop;
    chk("t1_rx_data", 32'(rx_data_o), 32'hA5);
    chk("t1_valid_count", 32'(nvalid - v0), 32'd1);
    v0 = nvalid;
    o0 = oe_cnt;
    do_start;
    addr_phase(8'hAA);
    data_byte(8'h02, -1);
    chk("t2_busy", 32'(busy_o), 32'd1);
    do_stop;
    chk("t2_busy_end", 32'(busy_o), 32'd0);
    chk("t2_oe_cycles", 32'(oe_cnt - o0), 32'd0);
    chk("t2_valid_count", 32'(nvalid - v0), 32'd0);
    s0 = seen.size();
    do_start;
    addr_phase(8'hE4);
    for (int i = 1; i <= 3; i++) data_byte(8'(i), -1);
    do_stop;
    chk("t3_valid_count", 32'(seen.size() - s0), 32'd3);
    if (seen.size() >= s0 + 3)
      for (int i = 0; i < 3; i++) chk("t3_byte", 32'(seen[s0 + i]), 32'(i + 1));
    do_start;
    addr_phase(8'hE5);
    data_byte(8'h11, -1);
    chk("t4_hit", 32'(addr_hit_o), 32'd0);
    chk("t4_busy", 32'(busy_o), 32'd1);
    do_stop;
    v0 = nvalid;
    do_start;
    addr_phase(8'hE4);
    partial(8'hF0, 4);
    do_start;
    addr_phase(8'hE4);
    data_byte(8'h3C, -1);
    do_stop;
    chk("t5_rx_data", 32'(rx_data_o), 32'h3C);
    chk("t5_valid_count", 32'(nvalid - v0), 32'd1);
    do_start;
    addr_phase(8'hE4);
    send_byte(8'h5A, 1'b0, -1, k);
    chk("t6_oe_before", 32'(sda_oe_o), 32'd1);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("t6_sda_oe", 32'(sda_oe_o), 32'd0);
    chk("t6_rx_valid", 32'(rx_valid_o), 32'd0);
    chk("t6_rx_data", 32'(rx_data_o), 32'd0);
    chk("t6_addr_hit", 32'(addr_hit_o), 32'd0);
    chk("t6_busy", 32'(busy_o), 32'd0);
    exp_busy = 1'b0;
    exp_hit = 1'b0;
    exp_oe = 1'b0;
    @(negedge clk);
    #1;
    rst = 1'b1;
    step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    -> glitch_ev;
    repeat (Q) @(negedge clk);
    #1;
    chk("t6_idle_glitch_busy", 32'(busy_o), 32'd0);
    do_start;
    addr_phase(8'hE4);
    data_byte(8'hFF, 4);
    chk("t6_glitch_hit", 32'(addr_hit_o), 32'd1);
    do_stop;
    chk("t6_glitch_rx", 32'(rx_data_o), 32'hFF);
    for (int t = 0; t < 15; t++) begin
      do_start;
      a = ($urandom_range(0, 2) == 0) ? 7'($urandom) : ADDR;
      addr_phase({a, 1'($urandom_range(0, 3) == 0)});
      nb = $urandom_range(0, 3);
      for (int j = 0; j < nb; j++) data_byte(8'($urandom), -1);
      if ($urandom_range(0, 4) == 0) partial(8'($urandom), $urandom_range(1, 7));
      if ($urandom_range(0, 3) != 0) do_stop;
    end
    if (exp_busy) do_stop;
    chk("rx_pending", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
